// File: rtl/spcpu_mem_arbiter.sv
// spcpu_mem_arbiter: two-port round-robin arbiter and sequencer for the
// single spcpu memory bus. Port 0 is the CPU path, port 1 a secondary master.
// One transaction in flight at a time: IDLE -> ACCESS -> DONE -> IDLE.
// Optional feature macro: MEM_ARB_TIMEOUT_EN (aborts ACCESS with err=1 after
// TIMEOUT_CYCLES cycles without mem_ack). Undefined: waits forever, err=0.
module spcpu_mem_arbiter #(
   parameter int ADDR_WIDTH     = 16,
   parameter int DATA_WIDTH     = 16,
   parameter int TIMEOUT_CYCLES = 15
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  r0_req,
   input  logic [ADDR_WIDTH-1:0] r0_addr,
   input  logic [DATA_WIDTH-1:0] r0_wdata,
   input  logic                  r0_we,
   input  logic                  r0_sz,
   output logic                  r0_gnt,
   output logic                  r0_done,
   output logic [DATA_WIDTH-1:0] r0_rdata,
   input  logic                  r1_req,
   input  logic [ADDR_WIDTH-1:0] r1_addr,
   input  logic [DATA_WIDTH-1:0] r1_wdata,
   input  logic                  r1_we,
   input  logic                  r1_sz,
   output logic                  r1_gnt,
   output logic                  r1_done,
   output logic [DATA_WIDTH-1:0] r1_rdata,
   output logic                  mem_req,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   output logic                  mem_we,
   output logic                  mem_sz,
   input  logic                  mem_ack,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   output logic                  err
);

   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

   // Requester fields gathered into per-port vectors so the winner can index them.
   logic [1:0]                 req_vec;
   logic [1:0][ADDR_WIDTH-1:0] addr_vec;
   logic [1:0][DATA_WIDTH-1:0] wdata_vec;
   logic [1:0]                 we_vec;
   logic [1:0]                 sz_vec;

   assign req_vec   = {r1_req, r0_req};
   assign addr_vec  = {r1_addr, r0_addr};
   assign wdata_vec = {r1_wdata, r0_wdata};
   assign we_vec    = {r1_we, r0_we};
   assign sz_vec    = {r1_sz, r0_sz};

   state_t                     state_reg, state_next;
   logic                       winner_reg, winner_next;
   logic                       last_winner_reg, last_winner_next;
   logic                       mem_req_reg, mem_req_next;
   logic [ADDR_WIDTH-1:0]      mem_addr_reg, mem_addr_next;
   logic [DATA_WIDTH-1:0]      mem_wdata_reg, mem_wdata_next;
   logic                       mem_we_reg, mem_we_next;
   logic                       mem_sz_reg, mem_sz_next;
   logic [1:0]                 gnt_reg, gnt_next;
   logic [1:0]                 done_reg, done_next;
   logic [1:0][DATA_WIDTH-1:0] rdata_reg, rdata_next;
   logic                       pick;
`ifdef MEM_ARB_TIMEOUT_EN
   localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);
   logic [7:0] cnt_reg, cnt_next;
   logic       err_reg, err_next;
`endif

   // State and output registers; last_winner resets to 1 so port 0 wins the first tie.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg       <= IDLE;
         winner_reg      <= 1'b0;
         last_winner_reg <= 1'b1;
         mem_req_reg     <= 1'b0;
         mem_addr_reg    <= '0;
         mem_wdata_reg   <= '0;
         mem_we_reg      <= 1'b0;
         mem_sz_reg      <= 1'b0;
         gnt_reg         <= '0;
         done_reg        <= '0;
         rdata_reg       <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
         cnt_reg         <= '0;
         err_reg         <= 1'b0;
`endif
      end else begin
         state_reg       <= state_next;
         winner_reg      <= winner_next;
         last_winner_reg <= last_winner_next;
         mem_req_reg     <= mem_req_next;
         mem_addr_reg    <= mem_addr_next;
         mem_wdata_reg   <= mem_wdata_next;
         mem_we_reg      <= mem_we_next;
         mem_sz_reg      <= mem_sz_next;
         gnt_reg         <= gnt_next;
         done_reg        <= done_next;
         rdata_reg       <= rdata_next;
`ifdef MEM_ARB_TIMEOUT_EN
         cnt_reg         <= cnt_next;
         err_reg         <= err_next;
`endif
      end
   end

   // Next-state logic: arbitrate in IDLE, wait for ack (or timeout) in ACCESS, retire in DONE.
   always_comb begin
      state_next       = state_reg;
      winner_next      = winner_reg;
      last_winner_next = last_winner_reg;
      mem_req_next     = mem_req_reg;
      mem_addr_next    = mem_addr_reg;
      mem_wdata_next   = mem_wdata_reg;
      mem_we_next      = mem_we_reg;
      mem_sz_next      = mem_sz_reg;
      gnt_next         = gnt_reg;
      done_next        = done_reg;
      rdata_next       = rdata_reg;
      pick             = 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
      cnt_next         = cnt_reg;
      err_next         = err_reg;
`endif
      case (state_reg)
         IDLE: begin
            if (|req_vec) begin
               // On a tie the port that did not win last time goes next.
               pick           = (&req_vec) ? ~last_winner_reg : req_vec[1];
               winner_next    = pick;
               mem_addr_next  = addr_vec[pick];
               mem_wdata_next = wdata_vec[pick];
               mem_we_next    = we_vec[pick];
               mem_sz_next    = sz_vec[pick];
               mem_req_next   = 1'b1;
               gnt_next       = '0;
               gnt_next[pick] = 1'b1;
               state_next     = ACCESS;
`ifdef MEM_ARB_TIMEOUT_EN
               cnt_next       = '0;
`endif
            end
         end
         ACCESS: begin
            if (mem_ack) begin
               mem_req_next          = 1'b0;
               done_next[winner_reg] = 1'b1;
               if (!mem_we_reg)
                  rdata_next[winner_reg] = mem_rdata;
               state_next            = DONE;
`ifdef MEM_ARB_TIMEOUT_EN
               err_next              = 1'b0;
            end else if (cnt_reg == TIMEOUT_LAST) begin
               mem_req_next          = 1'b0;
               done_next[winner_reg] = 1'b1;
               err_next              = 1'b1;
               state_next            = DONE;
            end else begin
               cnt_next              = cnt_reg + 8'd1;
`endif
            end
         end
         DONE: begin
            done_next        = '0;
            gnt_next         = '0;
            last_winner_next = winner_reg;
            state_next       = IDLE;
`ifdef MEM_ARB_TIMEOUT_EN
            err_next         = 1'b0;
`endif
         end
         default: state_next = IDLE;
      endcase
   end

   assign mem_req   = mem_req_reg;
   assign mem_addr  = mem_addr_reg;
   assign mem_wdata = mem_wdata_reg;
   assign mem_we    = mem_we_reg;
   assign mem_sz    = mem_sz_reg;
   assign r0_gnt    = gnt_reg[0];
   assign r1_gnt    = gnt_reg[1];
   assign r0_done   = done_reg[0];
   assign r1_done   = done_reg[1];
   assign r0_rdata  = rdata_reg[0];
   assign r1_rdata  = rdata_reg[1];
`ifdef MEM_ARB_TIMEOUT_EN
   assign err       = err_reg;
`else
   assign err       = 1'b0;
`endif

endmodule

// File: tb/tb_spcpu_mem_arbiter.sv
// Directed testbench for spcpu_mem_arbiter; honours MEM_ARB_TIMEOUT_EN.
module tb_spcpu_mem_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        r0_req, r0_we, r0_sz, r1_req, r1_we, r1_sz;
   logic [15:0] r0_addr, r0_wdata, r1_addr, r1_wdata;
   logic        r0_gnt, r0_done, r1_gnt, r1_done;
   logic [15:0] r0_rdata, r1_rdata;
   logic        mem_req, mem_we, mem_sz, mem_ack, err;
   logic [15:0] mem_addr, mem_wdata, mem_rdata;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   int last_done_cyc;
   logic seen_done;

   spcpu_mem_arbiter dut (
      .clk(clk), .reset(reset),
      .r0_req(r0_req), .r0_addr(r0_addr), .r0_wdata(r0_wdata), .r0_we(r0_we), .r0_sz(r0_sz),
      .r0_gnt(r0_gnt), .r0_done(r0_done), .r0_rdata(r0_rdata),
      .r1_req(r1_req), .r1_addr(r1_addr), .r1_wdata(r1_wdata), .r1_we(r1_we), .r1_sz(r1_sz),
      .r1_gnt(r1_gnt), .r1_done(r1_done), .r1_rdata(r1_rdata),
      .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
      .mem_sz(mem_sz), .mem_ack(mem_ack), .mem_rdata(mem_rdata), .err(err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b1;
      {r0_req, r0_we, r0_sz, r1_req, r1_we, r1_sz, mem_ack} = '0;
      {r0_addr, r0_wdata, r1_addr, r1_wdata, mem_rdata} = '0;
      #2 reset = 1'b0;

      // Reset state
      tick(); tick();
      chk("rst_mem_req", mem_req, 0);
      chk("rst_gnt", {r1_gnt, r0_gnt}, 0);
      chk("rst_done", {r1_done, r0_done}, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_rdata", {r1_rdata, r0_rdata}, 0);
      chk("rst_err", err, 0);
      reset = 1'b1;
      tick();

      // Test 1: r0 read of 0x0010, ack one cycle after mem_req
      r0_req = 1; r0_addr = 16'h0010; r0_we = 0; r0_sz = 1;
      tick();
      chk("t1_mem_req", mem_req, 1);
      chk("t1_gnt", {r1_gnt, r0_gnt}, 2'b01);
      chk("t1_addr", mem_addr, 16'h0010);
      chk("t1_we", mem_we, 0);
      chk("t1_done_early", r0_done, 0);
      mem_ack = 1; mem_rdata = 16'hBEEF;
      tick();
      chk("t1_done", {r1_done, r0_done}, 2'b01);
      chk("t1_rdata", r0_rdata, 16'hBEEF);
      chk("t1_mem_req_drop", mem_req, 0);
      chk("t1_r1_gnt", r1_gnt, 0);
      chk("t1_err", err, 0);
      mem_ack = 0; r0_req = 0;
      tick();
      chk("t1_done_pulse", r0_done, 0);
      chk("t1_gnt_clr", {r1_gnt, r0_gnt}, 0);
      tick();
      chk("t1_idle", mem_req, 0);

      // Test 6: mem_ack in IDLE with no request is ignored
      mem_ack = 1; mem_rdata = 16'h1111;
      tick(); tick();
      chk("t6_done", {r1_done, r0_done}, 0);
      chk("t6_r0_rdata", r0_rdata, 16'hBEEF);
      chk("t6_r1_rdata", r1_rdata, 0);
      chk("t6_mem_req", mem_req, 0);
      mem_ack = 0;

      // Test 4: reset during ACCESS drops the transaction
      r0_req = 1; r0_addr = 16'h0020;
      tick();
      chk("t4_mem_req", mem_req, 1);
      chk("t4_gnt", r0_gnt, 1);
      reset = 1'b0;
      #1;
      chk("t4_mem_req_rst", mem_req, 0);
      chk("t4_gnt_rst", r0_gnt, 0);
      chk("t4_done_rst", r0_done, 0);
      chk("t4_rdata_rst", r0_rdata, 0);
      mem_ack = 1;
      tick();
      r0_req = 0; mem_ack = 0; reset = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("t4_no_done", {r1_done, r0_done}, 0);
         chk("t4_no_req", mem_req, 0);
      end

      // Test 2: both request continuously -> r0, r1, r0, r1, done 3 cycles apart
      r0_addr = 16'h0100; r0_we = 0; r0_sz = 1;
      r1_addr = 16'h0200; r1_we = 0; r1_sz = 1;
      r0_req = 1; r1_req = 1;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("t2_gnt", {r1_gnt, r0_gnt}, (i % 2 == 0) ? 2'b01 : 2'b10);
         chk("t2_addr", mem_addr, (i % 2 == 0) ? 16'h0100 : 16'h0200);
         mem_ack = 1; mem_rdata = 16'hA000 + 16'(i);
         tick();
         chk("t2_done", {r1_done, r0_done}, (i % 2 == 0) ? 2'b01 : 2'b10);
         chk("t2_rdata", (i % 2 == 0) ? r0_rdata : r1_rdata, 16'hA000 + 16'(i));
         if (i > 0) chk("t2_spacing", cyc - last_done_cyc, 3);
         last_done_cyc = cyc;
         if (i == 3) begin r0_req = 0; r1_req = 0; end
         mem_ack = 0;
         tick();
      end

      // Test 3: r1 16-bit write, ack three cycles late
      r1_addr = 16'h8010; r1_wdata = 16'h1234; r1_we = 1; r1_sz = 1; r1_req = 1;
      tick();
      for (int k = 0; k < 3; k++) begin
         chk("t3_mem_req", mem_req, 1);
         chk("t3_fields", {mem_addr, mem_wdata, mem_we, mem_sz}, {16'h8010, 16'h1234, 2'b11});
         chk("t3_gnt", {r1_gnt, r0_gnt}, 2'b10);
         chk("t3_no_done", r1_done, 0);
         tick();
      end
      mem_ack = 1; mem_rdata = 16'hDEAD;
      tick();
      chk("t3_done", {r1_done, r0_done}, 2'b10);
      chk("t3_rdata_kept", r1_rdata, 16'hA003);
      chk("t3_err", err, 0);
      mem_ack = 0; r1_req = 0;
      tick();

      // Byte write: wdata passes unmodified, size latched as 0
      r0_addr = 16'h0011; r0_wdata = 16'hABCD; r0_we = 1; r0_sz = 0; r0_req = 1;
      tick();
      chk("t7_fields", {mem_addr, mem_wdata, mem_we, mem_sz}, {16'h0011, 16'hABCD, 2'b10});
      mem_ack = 1; mem_rdata = 16'h5555;
      tick();
      chk("t7_done", r0_done, 1);
      chk("t7_rdata_kept", r0_rdata, 16'hA002);
      mem_ack = 0; r0_req = 0;
      tick();

      // Test 5: no ack at all
      r0_addr = 16'h0042; r0_we = 0; r0_sz = 1; r0_req = 1;
      tick();
`ifdef MEM_ARB_TIMEOUT_EN
      repeat (14) tick();
      chk("t5_before_timeout", {r0_done, mem_req}, 2'b01);
      tick();
      chk("t5_timeout_done", {r0_done, err, mem_req}, 3'b110);
      chk("t5_rdata_kept", r0_rdata, 16'hA002);
      r0_req = 0;
      tick();
      chk("t5_err_clr", {r0_done, err}, 0);
`else
      seen_done = 0;
      repeat (100) begin
         tick();
         seen_done = seen_done | r0_done;
      end
      chk("t5_still_req", mem_req, 1);
      chk("t5_no_done", seen_done, 0);
      chk("t5_err", err, 0);
      mem_ack = 1; mem_rdata = 16'h7777;
      tick();
      chk("t5_late_done", r0_done, 1);
      chk("t5_late_rdata", r0_rdata, 16'h7777);
      mem_ack = 0; r0_req = 0;
      tick();
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
